// File: rtl/ascon_serial_io_if.sv
// Handshake and data bundle between the serial I/O block and its environment.
// The environment also stands in for the cipher core. It drives the serial
// inputs, start_req and the core results through the master modport. The
// serial I/O block sits on the slave modport.
interface ascon_serial_io_if #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int D = 3
);
  logic             load_valid;
  logic             load_ready;
  logic [D-1:0]     key_si;
  logic [D-1:0]     nonce_si;
  logic [D-1:0]     ad_si;
  logic [D-1:0]     pt_si;
  logic             start_req;
  logic             core_start;
  logic [D*K-1:0]   core_key;
  logic [D*128-1:0] core_nonce;
  logic [D*L-1:0]   core_ad;
  logic [D*Y-1:0]   core_pt;
  logic             core_done;
  logic [Y-1:0]     core_ct;
  logic [127:0]     core_tag;
  logic             ct_so;
  logic             tag_so;
  logic             out_valid;
  logic             busy;

  modport master (
    output load_valid, key_si, nonce_si, ad_si, pt_si, start_req,
           core_done, core_ct, core_tag,
    input  load_ready, core_start, core_key, core_nonce, core_ad, core_pt,
           ct_so, tag_so, out_valid, busy
  );

  modport slave (
    input  load_valid, key_si, nonce_si, ad_si, pt_si, start_req,
           core_done, core_ct, core_tag,
    output load_ready, core_start, core_key, core_nonce, core_ad, core_pt,
           ct_so, tag_so, out_valid, busy
  );
endinterface

// File: rtl/ascon_serial_io.sv
// Serial-to-parallel loader and parallel-to-serial drainer for a masked
// Ascon core. Shared key, nonce, AD and PT fields are shifted in MSB first,
// one bit per share per beat. The core is launched once on request, and the
// unmasked ct/tag results are streamed back out LSB first.
module ascon_serial_io #(
  parameter int K = 128,
  parameter int L = 40,
  parameter int Y = 40,
  parameter int D = 3
) (
  input logic              clk,
  input logic              rst,
  ascon_serial_io_if.slave bus
);
  localparam int KA   = (K > 128) ? K : 128;
  localparam int LY   = (L > Y) ? L : Y;
  localparam int MAXI = (KA > LY) ? KA : LY;
  localparam int MAXO = (Y > 128) ? Y : 128;
  localparam int MAXC = (MAXI > MAXO) ? MAXI : MAXO;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [D*K-1:0]   key_q, key_d;
  logic [D*128-1:0] nonce_q, nonce_d;
  logic [D*L-1:0]   ad_q, ad_d;
  logic [D*Y-1:0]   pt_q, pt_d;
  logic [Y-1:0]     ct_q, ct_d;
  logic [127:0]     tag_q, tag_d;
  logic             load_ready_q, load_ready_d;
  logic             core_start_q, core_start_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             ct_so_q, ct_so_d;
  logic             tag_so_q, tag_so_d;

  // Next-state, field capture and look-ahead of the registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    nonce_d      = nonce_q;
    ad_d         = ad_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    tag_d        = tag_q;
    core_start_d = 1'b0;
    case (state_q)
      S_LOAD: begin
        // The index decode also drops beats past a short field's width.
        for (int s = 0; s < D; s++) begin
          for (int b = 0; b < K; b++) begin
            key_d[s*K + K-1-b] = (bus.load_valid && int'(cnt_q) == b) ?
                                 bus.key_si[s] : key_q[s*K + K-1-b];
          end
          for (int b = 0; b < 128; b++) begin
            nonce_d[s*128 + 127-b] = (bus.load_valid && int'(cnt_q) == b) ?
                                     bus.nonce_si[s] : nonce_q[s*128 + 127-b];
          end
          for (int b = 0; b < L; b++) begin
            ad_d[s*L + L-1-b] = (bus.load_valid && int'(cnt_q) == b) ?
                                bus.ad_si[s] : ad_q[s*L + L-1-b];
          end
          for (int b = 0; b < Y; b++) begin
            pt_d[s*Y + Y-1-b] = (bus.load_valid && int'(cnt_q) == b) ?
                                bus.pt_si[s] : pt_q[s*Y + Y-1-b];
          end
        end
        if (bus.load_valid && cnt_q == CW'(MAXI-1)) begin
          state_d = S_READY;
          cnt_d   = {CW{1'b0}};
        end else if (bus.load_valid) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_READY: begin
        if (bus.start_req) begin
          state_d      = S_RUN;
          core_start_d = 1'b1;
        end else begin
          state_d = S_READY;
        end
      end
      S_RUN: begin
        if (bus.core_done) begin
          ct_d    = bus.core_ct;
          tag_d   = bus.core_tag;
          cnt_d   = {CW{1'b0}};
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(MAXO-1)) begin
          state_d = S_LOAD;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Serial outputs are registered from the next-cycle state, so they line
    // up with the cnt value that is current while they are visible.
    load_ready_d = (state_d == S_LOAD);
    out_valid_d  = (state_d == S_DRAIN);
    busy_d       = (state_d != S_LOAD);
    ct_so_d      = 1'b0;
    tag_so_d     = 1'b0;
    for (int i = 0; i < Y; i++) begin
      ct_so_d = ct_so_d | ((out_valid_d && int'(cnt_d) == i) ? ct_d[i] : 1'b0);
    end
    for (int i = 0; i < 128; i++) begin
      tag_so_d = tag_so_d | ((out_valid_d && int'(cnt_d) == i) ? tag_d[i] : 1'b0);
    end
  end

  // State, counter, field and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= {CW{1'b0}};
      key_q        <= {(D*K){1'b0}};
      nonce_q      <= {(D*128){1'b0}};
      ad_q         <= {(D*L){1'b0}};
      pt_q         <= {(D*Y){1'b0}};
      ct_q         <= {Y{1'b0}};
      tag_q        <= 128'd0;
      load_ready_q <= 1'b1;
      core_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ct_so_q      <= 1'b0;
      tag_so_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      ad_q         <= ad_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      tag_q        <= tag_d;
      load_ready_q <= load_ready_d;
      core_start_q <= core_start_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      ct_so_q      <= ct_so_d;
      tag_so_q     <= tag_so_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.core_start = core_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.ct_so      = ct_so_q;
  assign bus.tag_so     = tag_so_q;
  assign bus.core_key   = key_q;
  assign bus.core_nonce = nonce_q;
  assign bus.core_ad    = ad_q;
  assign bus.core_pt    = pt_q;
endmodule

// File: tb/tb_ascon_serial_io.sv
// Directed bench for ascon_serial_io with K=128, L=Y=40, D=3.
module tb_ascon_serial_io;
  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  logic [127:0] key_v, nonce_v;
  logic [39:0]  ad_v, pt_v;
  logic [383:0] exp_key, exp_nonce;
  logic [119:0] exp_ad, exp_pt;

  ascon_serial_io_if #(.K(128), .L(40), .Y(40), .D(3)) bus ();

  ascon_serial_io #(.K(128), .L(40), .Y(40), .D(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_idle(input string tag);
    vec_cnt++;
    if (bus.load_ready !== 1'b1 || bus.core_start !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.ct_so !== 1'b0 || bus.tag_so !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s: ready=%b start=%b ov=%b busy=%b ct=%b tag=%b, required 1 0 0 0 0 0",
               tag, bus.load_ready, bus.core_start, bus.out_valid, bus.busy, bus.ct_so, bus.tag_so);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load_valid = 1'b0; bus.key_si = 3'b000; bus.nonce_si = 3'b000;
    bus.ad_si = 3'b000; bus.pt_si = 3'b000; bus.start_req = 1'b0;
    bus.core_done = 1'b0; bus.core_ct = 40'd0; bus.core_tag = 128'd0;
    #2 rst = 1'b0;
    #1;
    check_idle("reset_async");
    vec_cnt++;
    if (bus.core_key !== 384'd0 || bus.core_ad !== 120'd0) begin
      err_cnt++;
      $display("FAIL reset_fields: key=%h ad=%h, required 0", bus.core_key, bus.core_ad);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_key = '0; exp_nonce = '0; exp_ad = '0; exp_pt = '0;
  endtask

  // Streams one full load starting at a negedge, optional idle gap before beat gap_at.
  task automatic do_load(input int gap_at, input int gap_len, output int cycles);
    logic [2:0] kb, nb, ab, pb;
    cycles = 0;
    for (int b = 0; b < 128; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.load_valid = 1'b0;
          bus.key_si = 3'($urandom_range(0, 7)); bus.nonce_si = 3'($urandom_range(0, 7));
          bus.ad_si = 3'($urandom_range(0, 7));  bus.pt_si = 3'($urandom_range(0, 7));
          @(posedge clk); cycles++; @(negedge clk);
        end
      end
      kb = 3'($urandom_range(0, 7)); nb = 3'($urandom_range(0, 7));
      ab = 3'($urandom_range(0, 7)); pb = 3'($urandom_range(0, 7));
      kb[0] = key_v[127-b];
      nb[0] = nonce_v[127-b];
      if (b < 40) begin
        ab[0] = ad_v[39-b];
        pb[0] = pt_v[39-b];
      end
      for (int s = 0; s < 3; s++) begin
        exp_key[s*128 + 127-b]   = kb[s];
        exp_nonce[s*128 + 127-b] = nb[s];
        if (b < 40) begin
          exp_ad[s*40 + 39-b] = ab[s];
          exp_pt[s*40 + 39-b] = pb[s];
        end
      end
      bus.load_valid = 1'b1;
      bus.key_si = kb; bus.nonce_si = nb; bus.ad_si = ab; bus.pt_si = pb;
      if (b == 127) begin
        vec_cnt++;
        if (bus.load_ready !== 1'b1) begin
          err_cnt++;
          $display("FAIL load_ready_last_beat: got %b, required 1", bus.load_ready);
        end
      end
      @(posedge clk); cycles++; @(negedge clk);
    end
    bus.load_valid = 1'b0;
  endtask

  task automatic check_fields(input string tag);
    vec_cnt++;
    if (bus.core_key !== exp_key || bus.core_nonce !== exp_nonce ||
        bus.core_ad !== exp_ad || bus.core_pt !== exp_pt) begin
      err_cnt++;
      $display("FAIL %s_fields: key=%h required %h", tag, bus.core_key, exp_key);
      $display("FAIL %s_fields: nonce=%h required %h ad=%h required %h pt=%h required %h",
               tag, bus.core_nonce, exp_nonce, bus.core_ad, exp_ad, bus.core_pt, exp_pt);
    end
    vec_cnt++;
    if (bus.core_key[127:0] !== 128'h2db083053e848cefa30007336c47a5a1 ||
        bus.core_nonce[127:0] !== 128'h3f3607dbce3503ba84f5843d623de056 ||
        bus.core_ad[39:0] !== 40'h4153434f4e || bus.core_pt[39:0] !== 40'h6173636f6e) begin
      err_cnt++;
      $display("FAIL %s_share0: key=%h nonce=%h ad=%h pt=%h, required fixed vectors",
               tag, bus.core_key[127:0], bus.core_nonce[127:0], bus.core_ad[39:0], bus.core_pt[39:0]);
    end
  endtask

  task automatic test_start_in_load();
    bus.start_req = 1'b1;
    bus.core_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_idle("start_in_load");
    end
    bus.start_req = 1'b0;
    bus.core_done = 1'b0;
  endtask

  task automatic test_load(input int gap_at, input int gap_len, input string tag);
    int cyc;
    do_load(gap_at, gap_len, cyc);
    vec_cnt++;
    if (cyc !== 128 + gap_len) begin
      err_cnt++;
      $display("FAIL %s_cycles: got %0d, required %0d", tag, cyc, 128 + gap_len);
    end
    vec_cnt++;
    if (bus.load_ready !== 1'b0 || bus.busy !== 1'b1 || bus.core_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_ready_state: ready=%b busy=%b start=%b, required 0 1 0",
               tag, bus.load_ready, bus.busy, bus.core_start);
    end
    check_fields(tag);
  endtask

  task automatic test_launch(input bit probe_done);
    if (probe_done) begin
      bus.core_done = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.core_done = 1'b0;
      vec_cnt++;
      if (bus.out_valid !== 1'b0 || bus.core_start !== 1'b0 || bus.busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL done_in_ready: ov=%b start=%b busy=%b, required 0 0 1",
                 bus.out_valid, bus.core_start, bus.busy);
      end
    end
    bus.start_req = 1'b1;
    @(posedge clk); @(negedge clk);
    vec_cnt++;
    if (bus.core_start !== 1'b1 || bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL launch_pulse: start=%b ov=%b, required 1 0", bus.core_start, bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      vec_cnt++;
      if (bus.core_start !== 1'b0) begin
        err_cnt++;
        $display("FAIL launch_repeat: start=%b, required 0", bus.core_start);
      end
    end
    bus.start_req = 1'b0;
  endtask

  task automatic test_drain(input logic [39:0] ct, input logic [127:0] tg, input int n);
    logic ect;
    bus.core_ct = ct; bus.core_tag = tg; bus.core_done = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.core_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      ect = (i < 40) ? ct[i] : 1'b0;
      vec_cnt++;
      if (bus.out_valid !== 1'b1 || bus.core_start !== 1'b0 || bus.ct_so !== ect ||
          bus.tag_so !== tg[i]) begin
        err_cnt++;
        $display("FAIL drain_bit%0d: ov=%b start=%b ct=%b tag=%b, required 1 0 %b %b",
                 i, bus.out_valid, bus.core_start, bus.ct_so, bus.tag_so, ect, tg[i]);
      end
      if (i < n - 1) begin
        @(posedge clk); @(negedge clk);
      end
    end
    if (n == 128) begin
      @(posedge clk); @(negedge clk);
      check_idle("drain_end");
      check_fields("drain_retained");
    end
  endtask

  task automatic test_reset_mid_drain();
    test_launch(1'b0);
    test_drain(40'hfedcba9876, 128'hffeeddccbbaa99887766554433221100, 11);
    #2 rst = 1'b0;
    #1;
    check_idle("reset_mid_drain");
    vec_cnt++;
    if (bus.core_key !== 384'd0 || bus.core_nonce !== 384'd0 ||
        bus.core_ad !== 120'd0 || bus.core_pt !== 120'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_drain_fields: key=%h, required 0", bus.core_key);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_key = '0; exp_nonce = '0; exp_ad = '0; exp_pt = '0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    key_v   = 128'h2db083053e848cefa30007336c47a5a1;
    nonce_v = 128'h3f3607dbce3503ba84f5843d623de056;
    ad_v    = 40'h4153434f4e;
    pt_v    = 40'h6173636f6e;
    test_reset();
    test_start_in_load();
    test_load(-1, 0, "load");
    test_launch(1'b1);
    test_drain(40'h0123456789, 128'h00112233445566778899aabbccddeeff, 128);
    test_load(60, 5, "gap");
    test_reset_mid_drain();
    test_load(-1, 0, "reload");
    test_launch(1'b0);
    test_drain(40'h0123456789, 128'h00112233445566778899aabbccddeeff, 128);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
